// File: rtl/pipeline_collapse.sv
// pipeline_collapse: valid/ready register pipeline whose stages advance
// independently, so bubbles collapse while the output is stalled. An optional
// input skid entry turns u_ready into a flop output. flush clears all beats.
module pipeline_collapse #(
   parameter int DATA_WIDTH      = 32,
   parameter int PIPELINE_STAGES = 4,
   parameter int READY_REG       = 0,
   localparam int CNT_W          = $clog2(PIPELINE_STAGES + 2)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] u_data,
   input  logic                  u_valid,
   output logic                  u_ready,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic                  d_valid,
   input  logic                  d_ready,
   output logic [CNT_W-1:0]      occupancy
);

   localparam int N = PIPELINE_STAGES;

   logic [N-1:0]          t_valid;
   logic [N-1:0]          t_valid_nxt;
   logic [DATA_WIDTH-1:0] t_data [N];
   logic [N:0]            rdy;
   logic                  chain;
   logic [N-1:0]          src_valid;
   logic [DATA_WIDTH-1:0] src_data [N];
   logic                  skid_valid;
   logic                  skid_valid_nxt;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CNT_W-1:0]      occ_nxt;

   // Ready chain from the output back to stage 0: a stage can load when it is
   // empty or when the stage ahead of it can load.
   always_comb begin
      // NOTE: chain is a blocking-assigned temporary in combinational logic;
      // it is read after being written within the same pass, never stored.
      chain  = d_ready;
      rdy[N] = chain;
      for (int i = N - 1; i >= 0; i--) begin
         chain  = ~t_valid[i] | chain;
         rdy[i] = chain;
      end
   end

   // Stage sources: stage 0 prefers a held skid beat over the upstream port.
   always_comb begin
      src_valid[0] = skid_valid | u_valid;
      src_data[0]  = skid_valid ? skid_data : u_data;
      for (int i = 1; i < N; i++) begin
         src_valid[i] = t_valid[i-1];
         src_data[i]  = t_data[i-1];
      end
   end

   // Next stage valids and the occupancy they imply.
   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      t_valid_nxt = t_valid;
      occ_nxt     = '0;
      if (flush) begin
         t_valid_nxt = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rdy[i]) t_valid_nxt[i] = src_valid[i];
         end
      end
      for (int i = 0; i < N; i++) begin
         occ_nxt = occ_nxt + CNT_W'(t_valid_nxt[i]);
      end
      occ_nxt = occ_nxt + CNT_W'(skid_valid_nxt);
   end

   generate
      if (READY_REG != 0) begin : g_skid
         assign u_ready = ~skid_valid & ~flush;

         // Skid fills when an accepted beat cannot enter stage 0 and empties
         // when stage 0 takes it; flush wins over both.
         always_comb begin
            skid_valid_nxt = skid_valid;
            if (flush)                          skid_valid_nxt = 1'b0;
            else if (u_valid & u_ready & ~rdy[0]) skid_valid_nxt = 1'b1;
            else if (rdy[0])                    skid_valid_nxt = 1'b0;
         end

         // Skid entry registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_valid <= 1'b0;
               skid_data  <= '0;
            end else begin
               skid_valid <= skid_valid_nxt;
               if (u_valid & u_ready & ~rdy[0]) skid_data <= u_data;
            end
         end
      end else begin : g_no_skid
         assign u_ready        = rdy[0] & ~flush;
         assign skid_valid     = 1'b0;
         assign skid_valid_nxt = 1'b0;
         assign skid_data      = '0;
      end
   endgenerate

   // Stage registers and occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_valid   <= '0;
         occupancy <= '0;
         // NOTE: the payload array is reset as well so that d_data is a known
         // zero after reset rather than whatever the flops powered up with.
         for (int i = 0; i < N; i++) t_data[i] <= '0;
      end else begin
         t_valid   <= t_valid_nxt;
         occupancy <= occ_nxt;
         for (int i = 0; i < N; i++) begin
            if (!flush && rdy[i] && src_valid[i]) t_data[i] <= src_data[i];
         end
      end
   end

   assign d_valid = t_valid[N-1] & ~flush;
   assign d_data  = t_data[N-1];

endmodule

// File: tb/tb_pipeline_collapse.sv
// tb_pipeline_collapse: drives three pipeline_collapse configurations
// (N=4 combinational ready, N=4 skid, N=1) with random traffic and compares
// every port each cycle against a beat-position reference model.
module tb_pipeline_collapse;

   logic        clk;
   logic        rst_n;
   logic        fl [3];
   logic        uv [3];
   logic        dr [3];
   logic [31:0] ud [3];

   logic        ur0, ur1, ur2;
   logic        dv0, dv1, dv2;
   logic [31:0] dd0, dd1, dd2;
   logic [2:0]  oc0, oc1;
   logic [1:0]  oc2;

   int n_cmp = 0;
   int n_err = 0;

   // configuration of each instance
   int n_st [3] = '{4, 4, 1};
   int rr   [3] = '{0, 1, 0};

   // model: beats in order oldest first; position -1 = skid, 0..N-1 = stage
   int          m_cnt [3];
   int          m_pos [3][8];
   logic [31:0] m_dat [3][8];

   pipeline_collapse #(.DATA_WIDTH(32), .PIPELINE_STAGES(4), .READY_REG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]), .u_data(ud[0]), .u_valid(uv[0]),
      .u_ready(ur0), .d_data(dd0), .d_valid(dv0), .d_ready(dr[0]), .occupancy(oc0));

   pipeline_collapse #(.DATA_WIDTH(32), .PIPELINE_STAGES(4), .READY_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]), .u_data(ud[1]), .u_valid(uv[1]),
      .u_ready(ur1), .d_data(dd1), .d_valid(dv1), .d_ready(dr[1]), .occupancy(oc1));

   pipeline_collapse #(.DATA_WIDTH(32), .PIPELINE_STAGES(1), .READY_REG(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(fl[2]), .u_data(ud[2]), .u_valid(uv[2]),
      .u_ready(ur2), .d_data(dd2), .d_valid(dv2), .d_ready(dr[2]), .occupancy(oc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic get_outs(input int i, output logic ur, output logic dv,
                           output logic [31:0] dd, output logic [31:0] oc);
      case (i)
         0:       begin ur = ur0; dv = dv0; dd = dd0; oc = 32'(oc0); end
         1:       begin ur = ur1; dv = dv1; dd = dd1; oc = 32'(oc1); end
         default: begin ur = ur2; dv = dv2; dd = dd2; oc = 32'(oc2); end
      endcase
   endtask

   // Compare this cycle's outputs, then advance the model across the next edge.
   task automatic check_and_step(input int i);
      int          in_stage;
      int          ahead;
      int          np;
      bit          has_skid;
      bit          eur;
      bit          edv;
      logic        ur, dv;
      logic [31:0] dd, oc;

      in_stage = 0;
      has_skid = 0;
      for (int k = 0; k < m_cnt[i]; k++) begin
         if (m_pos[i][k] >= 0) in_stage++;
         else                  has_skid = 1;
      end
      if (rr[i] != 0) eur = !fl[i] && !has_skid;
      else            eur = !fl[i] && (in_stage < n_st[i] || dr[i]);
      edv = !fl[i] && m_cnt[i] > 0 && m_pos[i][0] == n_st[i] - 1;

      get_outs(i, ur, dv, dd, oc);
      check($sformatf("i%0d u_ready", i), 32'(ur), 32'(eur));
      check($sformatf("i%0d d_valid", i), 32'(dv), 32'(edv));
      if (edv) check($sformatf("i%0d d_data", i), dd, m_dat[i][0]);
      check($sformatf("i%0d occupancy", i), oc, 32'(m_cnt[i]));

      if (fl[i]) begin
         m_cnt[i] = 0;
         return;
      end
      // a beat moves one place forward unless the beat ahead of it stays put
      // right in front; the oldest beat at the last stage leaves on d_ready
      ahead = n_st[i] + (dr[i] ? 1 : 0);
      for (int k = 0; k < m_cnt[i]; k++) begin
         np = (m_pos[i][k] + 1 < ahead) ? m_pos[i][k] + 1 : m_pos[i][k];
         m_pos[i][k] = np;
         ahead = np;
      end
      if (uv[i] && eur) begin
         m_pos[i][m_cnt[i]] = (0 < ahead) ? 0 : -1;
         m_dat[i][m_cnt[i]] = ud[i];
         m_cnt[i]++;
      end
      if (m_cnt[i] > 0 && m_pos[i][0] == n_st[i]) begin
         for (int k = 1; k < m_cnt[i]; k++) begin
            m_pos[i][k-1] = m_pos[i][k];
            m_dat[i][k-1] = m_dat[i][k];
         end
         m_cnt[i]--;
      end
   endtask

   task automatic run_phase(input int uv_pct, input int dr_pct, input int fl_pct, input int len);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            uv[i] = ($urandom_range(99) < uv_pct);
            dr[i] = ($urandom_range(99) < dr_pct);
            fl[i] = ($urandom_range(99) < fl_pct);
            ud[i] = $urandom;
         end
         #1;
         for (int i = 0; i < 3; i++) check_and_step(i);
      end
   endtask

   task automatic check_reset_state(input string when);
      logic        ur, dv;
      logic [31:0] dd, oc;
      for (int i = 0; i < 3; i++) begin
         get_outs(i, ur, dv, dd, oc);
         check($sformatf("i%0d %s d_valid", i, when), 32'(dv), 32'd0);
         check($sformatf("i%0d %s occupancy", i, when), oc, 32'd0);
         check($sformatf("i%0d %s u_ready", i, when), 32'(ur), 32'd1);
         m_cnt[i] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fl[i] = 1'b0; uv[i] = 1'b0; dr[i] = 1'b0; ud[i] = '0; m_cnt[i] = 0;
      end
      #2;
      check_reset_state("por");
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_phase(100, 100, 0, 20);   // back-to-back streaming
      run_phase(40, 100, 0, 40);    // sparse input, bubbles in flight
      run_phase(40, 0, 0, 8);       // sparse input, output stalled: collapse
      run_phase(100, 0, 0, 12);     // fill to full (skid takes one extra)
      run_phase(100, 100, 0, 20);   // full pass-through
      run_phase(0, 100, 0, 10);     // drain
      run_phase(70, 50, 5, 600);    // mixed traffic with flushes
      run_phase(90, 20, 3, 400);    // heavy backpressure
      run_phase(100, 0, 0, 10);     // fill before reset

      // asynchronous reset mid-stream, away from clock edges
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         uv[i] = 1'b0; fl[i] = 1'b0; dr[i] = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_state("async");
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_phase(100, 100, 0, 20);   // latency after reset
      run_phase(60, 60, 4, 600);
      run_phase(50, 100, 0, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
